dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Each line holds one 32-bit word. Addresses at or above MMIO_BASE bypass the cache.
`timescale 1ns/1ps

module dcache_ctrl #(
  parameter int          LINES     = 16,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        dstall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t state, state_nxt;

  // Line storage: only the valid bits are reset; they alone gate hits.
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // Transaction captured when leaving IDLE, so the memory request stays
  // stable even if the CPU inputs change.
  logic [29:0] lat_word;
  logic [31:0] lat_wdata;
  logic        lat_cacheable;
  logic [31:0] resp_data;

  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic             cpu_cacheable;
  logic             cpu_hit;
  logic             lat_tag_hit;
  logic             start_txn;
  logic             count_hit;
  logic             count_miss;
  logic             unused_addr_bits;

  assign cpu_idx          = cpu_addr[2+IDX_W-1:2];
  assign cpu_tag          = cpu_addr[31:2+IDX_W];
  assign lat_idx          = lat_word[IDX_W-1:0];
  assign lat_tag          = lat_word[29:IDX_W];
  assign cpu_cacheable    = (cpu_addr < MMIO_BASE);
  assign cpu_hit          = cpu_cacheable && valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign lat_tag_hit      = valid[lat_idx] && (tag_mem[lat_idx] == lat_tag);
  assign mem_addr         = {lat_word, 2'b00};
  assign mem_wdata        = lat_wdata;
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Next-state and output decode; stalls and memory requests follow the state.
  always_comb begin
    state_nxt  = state;
    dstall     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    cpu_rdata  = 32'h0;
    start_txn  = 1'b0;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            dstall    = 1'b1;
            start_txn = 1'b1;
            state_nxt = WRITE;
          end else if (cpu_hit) begin
            cpu_rdata = data_mem[cpu_idx];
            count_hit = 1'b1;
          end else begin
            dstall     = 1'b1;
            start_txn  = 1'b1;
            count_miss = cpu_cacheable;
            state_nxt  = FILL;
          end
        end
      end
      FILL: begin
        dstall  = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) state_nxt = RESP;
      end
      WRITE: begin
        dstall  = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_nxt = RESP;
      end
      RESP: begin
        cpu_rdata = resp_data;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding memory transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Capture the request on entry to FILL/WRITE and the fill data on acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_word      <= 30'h0;
      lat_wdata     <= 32'h0;
      lat_cacheable <= 1'b0;
      resp_data     <= 32'h0;
    end else begin
      if (start_txn) begin
        lat_word      <= cpu_addr[31:2];
        lat_wdata     <= cpu_wdata;
        lat_cacheable <= cpu_cacheable;
      end
      if (state == FILL && mem_ack) resp_data <= mem_rdata;
    end
  end

  // Valid bits: set by a cacheable fill, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid <= '0;
    else if (state == FILL && mem_ack && lat_cacheable) valid[lat_idx] <= 1'b1;
  end

  // Tag/data arrays: filled on load miss, patched on a store that hits (write-through).
  always_ff @(posedge clk) begin
    if (state == FILL && mem_ack && lat_cacheable) begin
      tag_mem[lat_idx]  <= lat_tag;
      data_mem[lat_idx] <= mem_rdata;
    end else if (state == WRITE && mem_ack && lat_cacheable && lat_tag_hit) begin
      data_mem[lat_idx] <= lat_wdata;
    end
  end

  // Saturating hit/miss performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= 16'h0;
      miss_cnt <= 16'h0;
    end else begin
      if (count_hit && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
      if (count_miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl with a line-level reference model.
`timescale 1ns/1ps

module tb_dcache_ctrl;

  localparam int          LINES     = 16;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        dstall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt, miss_cnt;

  dcache_ctrl #(.LINES(LINES), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .dstall(dstall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what each line holds, by full word address.
  bit          m_valid [LINES];
  logic [31:0] m_addr  [LINES];
  logic [31:0] m_data  [LINES];
  int          m_hits, m_misses;
  logic [31:0] m_resp;

  // Expected outputs for the current cycle.
  logic        exp_dstall, exp_mem_req, exp_mem_we, exp_chk_wdata;
  logic [31:0] exp_mem_addr, exp_mem_wdata, exp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    m_hits   = 0;
    m_misses = 0;
    m_resp   = 32'h0;
  endtask

  task automatic expectIdle();
    exp_dstall    = 1'b0;
    exp_mem_req   = 1'b0;
    exp_mem_we    = 1'b0;
    exp_chk_wdata = 1'b0;
    exp_mem_addr  = 32'h0;
    exp_mem_wdata = 32'h0;
    exp_rdata     = 32'h0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    checkOutput("dstall", {31'h0, dstall}, {31'h0, exp_dstall});
    checkOutput("mem_req", {31'h0, mem_req}, {31'h0, exp_mem_req});
    if (exp_mem_req) begin
      checkOutput("mem_we", {31'h0, mem_we}, {31'h0, exp_mem_we});
      checkOutput("mem_addr", mem_addr, exp_mem_addr);
      if (exp_chk_wdata) checkOutput("mem_wdata", mem_wdata, exp_mem_wdata);
    end
    checkOutput("cpu_rdata", cpu_rdata, exp_rdata);
    checkOutput("hit_cnt", {16'h0, hit_cnt}, m_hits);
    checkOutput("miss_cnt", {16'h0, miss_cnt}, m_misses);
  end

  // One full CPU access; returns the load data seen by the CPU on completion.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input int ack_delay, input logic [31:0] ack_data,
                               output logic [31:0] got);
    int idx;
    bit cacheable, hit;
    idx       = int'((addr >> 2) % LINES);
    cacheable = (addr < MMIO_BASE);
    hit       = !we && cacheable && m_valid[idx] && (m_addr[idx] == addr);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    expectIdle();
    exp_dstall = !hit;
    exp_rdata  = hit ? m_data[idx] : 32'h0;
    @(negedge clk);
    got = cpu_rdata;
    nextCycle();
    if (hit) begin
      if (m_hits < 65535) m_hits++;
      cpu_req = 1'b0;
      expectIdle();
      return;
    end
    if (!we && cacheable && m_misses < 65535) m_misses++;
    exp_dstall    = 1'b1;
    exp_mem_req   = 1'b1;
    exp_mem_we    = we;
    exp_mem_addr  = addr;
    exp_chk_wdata = we;
    exp_mem_wdata = wdata;
    exp_rdata     = 32'h0;
    for (int k = 0; k < ack_delay; k++) begin
      mem_ack   = (k == ack_delay - 1);
      mem_rdata = (k == ack_delay - 1) ? ack_data : (32'hA5A5_0000 + k);
      nextCycle();
    end
    mem_ack = 1'b0;
    if (!we) begin
      m_resp = ack_data;
      if (cacheable) begin
        m_valid[idx] = 1;
        m_addr[idx]  = addr;
        m_data[idx]  = ack_data;
      end
    end else if (cacheable && m_valid[idx] && m_addr[idx] == addr) begin
      m_data[idx] = wdata;
    end
    expectIdle();
    exp_rdata = m_resp;
    @(negedge clk);
    got = cpu_rdata;
    nextCycle();
    cpu_req = 1'b0;
    expectIdle();
  endtask

  task automatic idleCycles(input int n, input bit pulse_ack);
    cpu_req = 1'b0;
    expectIdle();
    for (int i = 0; i < n; i++) begin
      mem_ack   = pulse_ack;
      mem_rdata = 32'hBADD_0ACC;
      nextCycle();
    end
    mem_ack = 1'b0;
  endtask

  // Bound total run time.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    logic [31:0] got;
    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    modelReset();
    expectIdle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idleCycles(2, 1'b1);

    // Cold load, 3-cycle memory latency, then a hit on the same line.
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, got);
    checkOutput("cold_load_data", got, 32'hDEAD_BEEF);
    checkOutput("cold_load_miss_cnt", {16'h0, miss_cnt}, 32'd1);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1, 32'h0, got);
    checkOutput("hit_data", got, 32'hDEAD_BEEF);
    idleCycles(1, 1'b0);
    checkOutput("hit_cnt_one", {16'h0, hit_cnt}, 32'd1);

    // Conflict on index 0: 0x80 evicts 0x40, which then misses again.
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1, 32'h0, got);
    applyStimulus(1'b0, 32'h0000_0080, 32'h0, 2, 32'hCAFE_0080, got);
    checkOutput("conflict_data", got, 32'hCAFE_0080);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1, 32'h0BAD_0040, got);
    checkOutput("reload_miss_cnt", {16'h0, miss_cnt}, 32'd3);

    // Write-through store to a cached line, then a store to an absent line.
    applyStimulus(1'b1, 32'h0000_0040, 32'h1234_5678, 2, 32'h0, got);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1, 32'h0, got);
    checkOutput("store_hit_data", got, 32'h1234_5678);
    applyStimulus(1'b1, 32'h0000_0044, 32'h5555_AAAA, 1, 32'h0, got);
    applyStimulus(1'b0, 32'h0000_0044, 32'h0, 2, 32'h0044_0044, got);
    checkOutput("no_alloc_miss_cnt", {16'h0, miss_cnt}, 32'd4);

    // Uncached MMIO loads always go to memory and leave counters alone.
    applyStimulus(1'b0, 32'hFFFF_FC00, 32'h0, 2, 32'h0000_0011, got);
    checkOutput("mmio_first", got, 32'h0000_0011);
    applyStimulus(1'b0, 32'hFFFF_FC00, 32'h0, 1, 32'h0000_0022, got);
    checkOutput("mmio_second", got, 32'h0000_0022);
    checkOutput("mmio_hit_cnt", {16'h0, hit_cnt}, 32'd3);
    checkOutput("mmio_miss_cnt", {16'h0, miss_cnt}, 32'd4);

    // Reset in the middle of a fill; the late acknowledge must be ignored.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0108;
    expectIdle();
    exp_dstall = 1'b1;
    nextCycle();
    m_misses++;
    exp_mem_req  = 1'b1;
    exp_mem_we   = 1'b0;
    exp_mem_addr = 32'h0000_0108;
    nextCycle();
    rst     = 1'b0;
    cpu_req = 1'b0;
    modelReset();
    expectIdle();
    nextCycle();
    rst = 1'b1;
    idleCycles(1, 1'b1);
    idleCycles(1, 1'b0);
    applyStimulus(1'b0, 32'h0000_0108, 32'h0, 2, 32'h0000_0077, got);
    checkOutput("post_reset_data", got, 32'h0000_0077);
    checkOutput("post_reset_miss_cnt", {16'h0, miss_cnt}, 32'd1);

    // Saturate the hit counter and confirm it holds.
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_4040, got);
    for (int i = 0; i < 65535; i++)
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1, 32'h0, got);
    idleCycles(1, 1'b0);
    checkOutput("hit_cnt_full", {16'h0, hit_cnt}, 32'h0000_FFFF);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1, 32'h0, got);
    checkOutput("sat_hit_data", got, 32'h0000_4040);
    idleCycles(1, 1'b0);
    checkOutput("hit_cnt_saturated", {16'h0, hit_cnt}, 32'h0000_FFFF);
    checkOutput("sat_miss_cnt", {16'h0, miss_cnt}, 32'd2);

    idleCycles(2, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
